// File: rtl/sequence_gen.sv
// Fixed eight-entry 4-bit pattern generator: A, B, E, 7, F, 2, 0, D, advancing
// one entry per enabled clock, with a registered output and synchronous reset.
module sequence_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [3:0] data
);

    logic [2:0] idx;
    logic [3:0] rom_value;

    always_comb begin
        // NOTE: a default on every path of a combinational block keeps synthesis
        // from inferring a latch when a case item is ever left uncovered.
        rom_value = 4'h0;
        case (idx)
            3'd0: rom_value = 4'hA;
            3'd1: rom_value = 4'hB;
            3'd2: rom_value = 4'hE;
            3'd3: rom_value = 4'h7;
            3'd4: rom_value = 4'hF;
            3'd5: rom_value = 4'h2;
            3'd6: rom_value = 4'h0;
            3'd7: rom_value = 4'hD;
            default: rom_value = 4'h0;
        endcase
    end

    // The 3-bit index wraps from 7 to 0 by plain rollover.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order.
        if (reset) begin
            data <= 4'h0;
            idx  <= 3'd0;
        end else if (enable) begin
            data <= rom_value;
            idx  <= idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_sequence_gen.sv
// Scoreboard bench for sequence_gen: stimulus pushes the model's expected data
// per clock edge, and a falling-edge monitor pops and compares.
module tb_sequence_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] data;

    typedef struct {
        logic [3:0] value;
        string      tag;
    } expect_t;

    expect_t    sb[$];
    int         checks = 0;
    int         errors = 0;
    int         enabled_edges = 0;
    logic [3:0] pattern [8] = '{4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD};

    sequence_gen dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .data   (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: data=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Model: output is the pattern entry for the number of enabled edges since reset.
    task automatic step(input logic r, input logic e, input string tag);
        expect_t x;
        reset  = r;
        enable = e;
        if (r) enabled_edges = 0;
        else if (e) enabled_edges++;
        x.value = (enabled_edges == 0) ? 4'h0 : pattern[(enabled_edges - 1) % 8];
        x.tag   = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        expect_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(x.tag, data, x.value);
            end
        end
    end

    initial begin : stimulus
        int waited;
        logic r;
        logic e;

        step(1'b1, 1'b0, "reset_idle");
        step(1'b1, 1'b0, "reset_idle");
        step(1'b0, 1'b0, "idle_after_reset");

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "full_cycle_wrap");

        step(1'b0, 1'b1, "advance_to_e");
        step(1'b0, 1'b1, "advance_to_7");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold_7");
        step(1'b0, 1'b1, "resume_f");

        step(1'b1, 1'b1, "midrun_reset");
        step(1'b0, 1'b1, "restart_a");

        step(1'b1, 1'b1, "reset_priority");
        step(1'b1, 1'b1, "reset_priority");
        step(1'b0, 1'b1, "restart_after_priority");
        step(1'b0, 1'b1, "restart_after_priority");

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, "random");
        end
        step(1'b0, 1'b0, "final_hold");

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_gen.md
# sequence_gen

Fixed-pattern 4-bit sequence generator. While enabled it emits the eight-value cycle A, B, E, 7, F, 2, 0, D, one value per clock, and wraps back to A after D. The output is registered and intended to drive a downstream datapath or pattern checker directly. There is no handshake: consumers sample `data` every clock.

## Interface
- Parameters: none. Data width (4) and sequence length (8) are fixed.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  one clock; reset is synchronous and active-high.
- `enable`  input  1  advance request, sampled on the rising edge of `clk`.
- `data`  output  4  registered sequence value.

## Operation
- Internal state:
  - 3-bit index `idx` (0..7).
  - 4-bit output register `data`.
- Sequence ROM, indexed by `idx`:
  - 0→4'hA, 1→4'hB, 2→4'hE, 3→4'h7
  - 4→4'hF, 5→4'h2, 6→4'h0, 7→4'hD
- Rising edge with `reset`=1:
  - `data` ← 4'h0, `idx` ← 0.
  - Reset takes priority over `enable`.
- Rising edge with `reset`=0 and `enable`=1:
  - `data` ← ROM[`idx`].
  - `idx` ← `idx`+1, modulo 8.
  - Wrap from 7 to 0 is natural 3-bit rollover with no extra state.
- Rising edge with `reset`=0 and `enable`=0:
  - `data` and `idx` hold.
  - Resuming `enable` continues from the held index. It does not restart at A.
- `data` is driven only by the register. There is no combinational path from `enable` or `idx` to `data`.
- X/Z on `enable` while `reset`=0 is a don't-care input condition. The implementation needs no special handling for it.

## Timing
- Reset value of `data`: 4'h0. Reset value of `idx`: 0.
- Latency: `data` shows 4'hA after the first enabled rising edge following reset. It is stable from that edge until the next enabled edge.
- Each subsequent enabled edge presents the next ROM entry. Throughput is one value per enabled cycle.
- Ninth enabled edge after reset: `data` = 4'hA again (wrap-around). The period is exactly 8 enabled cycles.
- `enable` deasserted for N cycles: `data` keeps its current value for those N cycles.
- Reset asserted mid-sequence:
  - On the next rising edge, `data`=0 and `idx`=0.
  - The first enabled edge after reset deasserts yields 4'hA.
- Reset asserted with `enable` high: reset wins and `data`=0.
- Asynchronous assertion of `reset` has no effect until the next rising edge.
- Outputs are valid for sampling on the falling edge between rising edges.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset`=1 for 2 cycles with `enable`=0, then release `reset` for 1 cycle.
  - Required: `data`=0 throughout; `idx` does not advance.
- Full cycle:
  - Stimulus: assert `enable`; sample on successive falling edges.
  - Required: `data` = A, B, E, 7, F, 2, 0, D on consecutive cycles.
- Wrap:
  - Stimulus: keep `enable`=1 beyond D.
  - Required: 9th sample = A, 10th = B; the pattern repeats indefinitely.
- Hold:
  - Stimulus: after `data`=7, drop `enable` for 3 cycles, then reassert it.
  - Required: `data` stays 7 for 3 cycles; the next enabled edge gives F.
- Mid-run reset:
  - Stimulus: with `enable`=1 and `data`=F, pulse `reset` for 1 cycle.
  - Required: `data`=0 after that edge; the next enabled edge gives A.
- Reset priority:
  - Stimulus: drive `reset`=1 and `enable`=1 together for 2 cycles.
  - Required: `data`=0 on both cycles; sequence restarts at A after release.
